// File: rtl/io_uart.sv
// io_uart: memory-mapped UART transmitter (8N1) with an LED register.
// Register map on IO_A[3:2]: 0 DATA, 1 STATUS, 2 DIV, 3 LEDS.
// Define UART_FIFO_EN to get a FIFO_DEPTH-entry TX FIFO; without it a single
// holding register buffers the next byte.
module io_uart #(
  parameter logic [15:0] DIV_RESET  = 16'd868,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IO_A,
  input  logic [1:0]  IOReadS,
  input  logic        IOWriteS,
  input  logic [31:0] IO_write,
  output logic [31:0] IO_dout,
  output logic        uart_tx,
  output logic [7:0]  leds
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      state, state_nx;
  logic [15:0] div, fdiv, cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        ovf;

  logic [1:0]  sel;
  logic        wr_data, wr_stat, wr_div, wr_led;
  logic        bit_end, pop, push, accept, drop, busy;
  logic        full, empty;
  logic [7:0]  pop_data;
  logic [3:0]  count4;
  logic        unused;

  assign sel     = IO_A[3:2];
  assign wr_data = IOWriteS && (sel == 2'd0);
  assign wr_stat = IOWriteS && (sel == 2'd1);
  assign wr_div  = IOWriteS && (sel == 2'd2);
  assign wr_led  = IOWriteS && (sel == 2'd3);
  assign unused  = ^{IO_A[31:4], IO_A[1:0], IO_write[31:16]};

  assign busy    = (state != S_IDLE);
  assign bit_end = (cnt == 16'd0);
  // A byte may leave the buffer from IDLE or at the last cycle of a stop bit,
  // which makes back-to-back frames gapless.
  assign pop     = ((state == S_IDLE) || (state == S_STOP && bit_end)) && !empty;
  assign push    = wr_data;
  assign accept  = push && (!full || pop);
  assign drop    = push && full && !pop;

`ifdef UART_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rptr];
  assign count4   = 4'(count);

  // FIFO storage, no reset needed on the data array
  always_ff @(posedge CLK) begin
    if (accept) mem[wptr] <= IO_write[7:0];
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  logic [7:0] hold;
  logic       hold_vld;

  assign full     = hold_vld;
  assign empty    = !hold_vld;
  assign pop_data = hold;
  assign count4   = {3'b000, hold_vld};

  // Single holding register; a push in the same cycle as a pop refills it
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hold     <= 8'h00;
      hold_vld <= 1'b0;
    end else if (accept) begin
      hold     <= IO_write[7:0];
      hold_vld <= 1'b1;
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end
`endif

  // Software-visible registers and the sticky overflow flag
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div  <= DIV_RESET;
      leds <= 8'h00;
      ovf  <= 1'b0;
    end else begin
      if (wr_div) div <= (IO_write[15:0] == 16'd0) ? 16'd1 : IO_write[15:0];
      if (wr_led) leds <= IO_write[7:0];
      if (drop)                      ovf <= 1'b1;
      else if (wr_stat && IO_write[3]) ovf <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Bit timer, bit index and shift register; divisor latched per frame
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fdiv    <= DIV_RESET;
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else if (pop) begin
      fdiv    <= div;
      cnt     <= div - 16'd1;
      shreg   <= pop_data;
      bit_idx <= 3'd0;
    end else if (state != S_IDLE) begin
      if (bit_end) begin
        cnt <= fdiv - 16'd1;
        if (state == S_DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        cnt <= cnt - 16'd1;
      end
    end
  end

  // Next-state logic and line level
  always_comb begin
    state_nx = state;
    uart_tx  = 1'b1;
    case (state)
      S_IDLE:  if (!empty) state_nx = S_START;
      S_START: begin
        uart_tx = 1'b0;
        if (bit_end) state_nx = S_DATA;
      end
      S_DATA: begin
        uart_tx = shreg[0];
        if (bit_end && bit_idx == 3'd7) state_nx = S_STOP;
      end
      S_STOP:  if (bit_end) state_nx = empty ? S_IDLE : S_START;
      default: state_nx = S_IDLE;
    endcase
  end

  // Read mux, zero when no read strobe
  always_comb begin
    IO_dout = 32'h0;
    if (|IOReadS) begin
      case (sel)
        2'd1:    IO_dout = {24'h0, count4, ovf, empty, full, busy};
        2'd2:    IO_dout = {16'h0, div};
        2'd3:    IO_dout = {24'h0, leds};
        default: IO_dout = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// Testbench for io_uart: register table, directed frame sequences and random
// traffic checked each cycle against a frame-schedule model of the line.
module tb_io_uart;
`ifdef UART_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [15:0] DIV_RST = 16'd868;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] IO_A = 32'h0;
  logic [1:0]  IOReadS = 2'b00;
  logic        IOWriteS = 1'b0;
  logic [31:0] IO_write = 32'h0;
  logic [31:0] IO_dout;
  logic        uart_tx;
  logic [7:0]  leds;

  io_uart #(.DIV_RESET(DIV_RST), .FIFO_DEPTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .IO_A(IO_A), .IOReadS(IOReadS),
    .IOWriteS(IOWriteS), .IO_write(IO_write), .IO_dout(IO_dout),
    .uart_tx(uart_tx), .leds(leds)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int nerr = 0;
  int nchk = 0;

  // Model: every accepted byte becomes a frame with a start edge and divisor.
  int         f_start[$];
  int         f_div[$];
  logic [7:0] f_data[$];
  int         m_div;
  logic       m_ovf;

  function automatic logic model_tx(int e);
    int o, b;
    for (int i = 0; i < f_start.size(); i++) begin
      o = e - f_start[i];
      if (o >= 0 && o < 10 * f_div[i]) begin
        b = o / f_div[i];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return f_data[i][b-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic int last_end();
    if (f_start.size() == 0) return 0;
    return f_start[f_start.size()-1] + 10 * f_div[f_div.size()-1];
  endfunction

  function automatic int pending(int e);
    int n = 0;
    for (int i = 0; i < f_start.size(); i++) if (f_start[i] > e) n++;
    return n;
  endfunction

  function automatic logic busy_at(int e);
    for (int i = 0; i < f_start.size(); i++)
      if (e >= f_start[i] && e < f_start[i] + 10 * f_div[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_status(int e);
    int n = pending(e);
    return {24'h0, 4'(n), m_ovf, (n == 0), (n == DEPTH), busy_at(e)};
  endfunction

  function automatic logic [31:0] mk_addr(logic [1:0] s);
    logic [31:0] a;
    a = $urandom;
    a[3:2] = s;
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Advance to the next falling edge and check the line against the model
  task automatic step();
    @(negedge CLK);
    check($sformatf("tx@%0d", cyc), 32'(uart_tx), 32'(model_tx(cyc)));
  endtask

  task automatic wr(input logic [1:0] s, input logic [31:0] d);
    int e, st;
    e = cyc + 1;
    IO_A = mk_addr(s); IO_write = d; IOWriteS = 1'b1;
    case (s)
      2'd0: begin
        if (pending(e) >= DEPTH) m_ovf = 1'b1;
        else begin
          st = (last_end() > e + 1) ? last_end() : e + 1;
          f_start.push_back(st); f_div.push_back(m_div); f_data.push_back(d[7:0]);
        end
      end
      2'd1: if (d[3]) m_ovf = 1'b0;
      2'd2: m_div = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
      default: ;
    endcase
    step();
    IOWriteS = 1'b0; IO_write = $urandom;
  endtask

  task automatic rd(input logic [1:0] s, input logic [1:0] rs, input logic [31:0] exp,
                    input string name, output logic [31:0] got);
    IO_A = mk_addr(s); IOReadS = rs;
    #1;
    got = IO_dout;
    check(name, IO_dout, exp);
    IOReadS = 2'b00;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    check("tx_async_reset", 32'(uart_tx), 32'h1);
    f_start.delete(); f_div.delete(); f_data.delete();
    m_div = int'(DIV_RST); m_ovf = 1'b0;
    step(); step();
    check("leds_reset", 32'(leds), 32'h0);
    RESET = 1'b0;
  endtask

  task automatic wait_idle();
    int t = last_end() + 2;
    while (cyc < t) step();
  endtask

  typedef struct {
    bit          w;
    logic [1:0]  rs;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[12];
    logic [31:0] got;
    logic        bits55[10];
    int          s, n, gap, d;

    tbl[0]  = '{0, 2'd1, 2'd1, 32'h0,        32'h0000_0004};
    tbl[1]  = '{0, 2'd2, 2'd2, 32'h0,        32'h0000_0364};
    tbl[2]  = '{0, 2'd3, 2'd3, 32'h0,        32'h0000_0000};
    tbl[3]  = '{1, 2'd0, 2'd3, 32'hFFFF_FFA5, 32'h0};
    tbl[4]  = '{0, 2'd1, 2'd3, 32'h0,        32'h0000_00A5};
    tbl[5]  = '{0, 2'd0, 2'd3, 32'h0,        32'h0000_0000};
    tbl[6]  = '{1, 2'd0, 2'd2, 32'hABCD_0000, 32'h0};
    tbl[7]  = '{0, 2'd2, 2'd2, 32'h0,        32'h0000_0001};
    tbl[8]  = '{1, 2'd0, 2'd2, 32'h0001_0007, 32'h0};
    tbl[9]  = '{0, 2'd3, 2'd2, 32'h0,        32'h0000_0007};
    tbl[10] = '{0, 2'd1, 2'd0, 32'h0,        32'h0000_0000};
    tbl[11] = '{0, 2'd1, 2'd1, 32'h0,        32'h0000_0004};

    m_div = int'(DIV_RST); m_ovf = 1'b0;
    step();
    do_reset();

    // Register table
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].w) wr(tbl[i].sel, tbl[i].data);
      else rd(tbl[i].sel, tbl[i].rs, tbl[i].exp, $sformatf("tbl%0d", i), got);
    end
    check("leds_port", 32'(leds), 32'h0000_00A5);

    // 0x55 at DIV=4: start at next edge, alternating bits, idle after 40
    bits55 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h55);
    s = cyc + 1;
    check("tx_high_at_write_edge", 32'(uart_tx), 32'h1);
    step();
    check("start_bit_next_edge", 32'(uart_tx), 32'h0);
    for (int k = 0; k < 10; k++) begin
      while (cyc < s + 2 + 4 * k) step();
      check($sformatf("frame55_bit%0d", k), 32'(uart_tx), 32'(bits55[k]));
    end
    while (cyc < s + 40) step();
    check("idle_after_40", 32'(uart_tx), 32'h1);
    rd(2'd1, 2'd1, 32'h4, "status_idle_55", got);

    // Three bytes back to back
    wr(2'd0, 32'h01); wr(2'd0, 32'h02); wr(2'd0, 32'h03);
    wait_idle();
    rd(2'd1, 2'd1, exp_status(cyc), "status_after_3", got);
    check("empty_after_3", 32'(got[2]), 32'h1);
    wr(2'd1, 32'h8);

    // Overflow: one in flight, buffer filled, one more dropped
    for (int i = 0; i < DEPTH + 2; i++) wr(2'd0, 32'(8'hC0 + i));
    rd(2'd1, 2'd3, exp_status(cyc), "status_ovf", got);
    check("ovf_set", 32'(got[3]), 32'h1);
    wr(2'd1, 32'h8);
    rd(2'd1, 2'd1, exp_status(cyc), "status_ovf_clr", got);
    check("ovf_clear", 32'(got[3]), 32'h0);
    wait_idle();

    // DIV change mid-frame affects only the next frame
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h96);
    repeat (10) step();
    wr(2'd2, 32'd5);
    wr(2'd0, 32'h3C);
    wait_idle();

    // DIV=0 stored as 1: 10-cycle frame
    wr(2'd2, 32'd0);
    rd(2'd2, 2'd1, 32'h1, "div_zero_reads_1", got);
    wr(2'd0, 32'h00);
    s = cyc + 1;
    while (cyc < s + 8) step();
    check("div1_last_data", 32'(uart_tx), 32'h0);
    step();
    check("div1_stop", 32'(uart_tx), 32'h1);
    rd(2'd1, 2'd1, 32'h5, "div1_status_stop", got);
    step();
    rd(2'd1, 2'd1, 32'h4, "div1_status_done", got);

    // Reset during data bit 3
    wr(2'd2, 32'd4);
    wr(2'd0, 32'hA5);
    s = cyc + 1;
    wr(2'd0, 32'h5A);
    while (cyc < s + 18) step();
    do_reset();
    rd(2'd1, 2'd1, 32'h4, "status_after_abort", got);
    rd(2'd2, 2'd1, 32'(DIV_RST), "div_after_abort", got);
    repeat (60) step();

    // Random traffic
    for (int sc = 0; sc < 15; sc++) begin
      wait_idle();
      d = $urandom_range(1, 5);
      wr(2'd2, 32'(d));
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) begin
        gap = ($urandom % 3 == 0) ? 0 : $urandom_range(0, 12 * d);
        repeat (gap) step();
        if ($urandom % 4 == 0)
          rd(2'd1, 2'($urandom_range(1, 3)), exp_status(cyc), "rand_status", got);
        if ($urandom % 6 == 0) wr(2'd1, $urandom);
        wr(2'd0, $urandom);
      end
      wait_idle();
      rd(2'd1, 2'd1, exp_status(cyc), "rand_status_end", got);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/io_uart.md
IO_UART -- requirements
Module: io_uart

Interface
REQ-001 SHALL have parameter DIV_RESET, default 16'd868, reset value of the baud divisor (cycles per bit).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two) when UART_FIFO_EN is defined.
REQ-003 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port IO_A  input  32  IO byte address; only IO_A[3:2] decoded.
REQ-006 SHALL have port IOReadS  input  2  read strobe; read active when any bit is 1.
REQ-007 SHALL have port IOWriteS  input  1  write strobe, one-cycle pulse per store.
REQ-008 SHALL have port IO_write  input  32  store data.
REQ-009 SHALL have port IO_dout  output  32  load data.
REQ-010 SHALL have port uart_tx  output  1  serial line, 8N1, idle high.
REQ-011 SHALL have port leds  output  8  LED register.

Function
REQ-012 SHALL decode IO_A[3:2]: 0 DATA, 1 STATUS, 2 DIV, 3 LEDS.
REQ-013 SHALL, on IOWriteS with DATA selected, push IO_write[7:0] into the TX buffer at that edge.
REQ-014 SHALL, on IOWriteS with DIV selected, load IO_write[15:0]; a value of 0 is stored as 1.
REQ-015 SHALL, on IOWriteS with LEDS selected, load IO_write[7:0] into leds.
REQ-016 SHALL, on IOWriteS with STATUS selected and IO_write[3]=1, clear the overflow flag.
REQ-017 SHALL drive IO_dout combinationally: 0 when no read; DATA reads 0; STATUS = {24'b0, count[3:0], overflow, empty, full, busy}; DIV = {16'b0, div}; LEDS = {24'b0, leds}.
REQ-018 SHALL implement FSM IDLE, START, DATA, STOP; busy = state != IDLE.
REQ-019 SHALL, in IDLE with buffer non-empty, pop one byte at the next edge, enter START and drive uart_tx low; a byte written at edge n starts its start bit at edge n+1.
REQ-020 SHALL hold each bit for exactly div cycles using a 16-bit down-counter reloaded at every bit boundary.
REQ-021 SHALL shift 8 data bits LSB first in DATA (3-bit bit index, 0..7), then drive 1 for div cycles in STOP.
REQ-022 SHALL, at STOP end, go to START with the next popped byte if the buffer is non-empty (no idle gap), else to IDLE; frame length is exactly 10*div cycles.
REQ-023 SHALL latch div at frame start; DIV writes mid-frame affect only subsequent frames.
REQ-024 SHALL, on push while full and no pop that edge, drop the byte and set overflow (sticky).
REQ-025 SHALL, on push and pop at the same edge while full, accept the push; count unchanged, overflow not set.
REQ-026 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; count saturates at FIFO_DEPTH (full), 0 (empty).
REQ-027 SHALL ignore reads for side effects (no pop, no flag clear on read).

Reset
REQ-028 SHALL, while RESET=1 asynchronously, force state IDLE, uart_tx=1, leds=0, div=DIV_RESET, FIFO pointers and count 0, overflow 0, bit counter 0.
REQ-029 SHALL abort any frame in progress on RESET, returning uart_tx to 1 immediately; buffered bytes are discarded.

Configuration
REQ-030 SHALL, with UART_FIFO_EN defined, buffer FIFO_DEPTH bytes; full = count==FIFO_DEPTH.
REQ-031 SHALL, without UART_FIFO_EN, use a single holding register: full = holding valid, count field reads 0 or 1, all other behaviour identical.

Verification
REQ-032 SHALL cover: reset, write DIV=4, DATA=0x55 -> uart_tx low at next edge, bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high, IDLE after 40 cycles.
REQ-033 SHALL cover: (FIFO_EN) write 0x01,0x02,0x03 back-to-back, DIV=4 -> three frames contiguous, 120 cycles, no idle gap, STATUS empty=1 afterward.
REQ-034 SHALL cover: fill buffer while busy then one more write -> STATUS overflow=1, dropped byte never transmitted; write STATUS 0x8 -> overflow=0.
REQ-035 SHALL cover: write LEDS 0xA5, read LEDS -> leds=0xA5, IO_dout=0x000000A5; read with IOReadS=0 -> IO_dout=0.
REQ-036 SHALL cover: assert RESET mid-DATA bit 3 -> uart_tx=1, STATUS=0x4 (empty), div=DIV_RESET, no residual transmission.
REQ-037 SHALL cover: write DIV=0 -> DIV reads 1, subsequent frame 10 cycles.
